// File: rtl/acortex_lb_arb.sv
// Two-master round-robin arbiter for the Acortex local bus.
// Turns level requests into one-cycle LB strobes, then returns done/err/data.
module acortex_lb_arb #(
   parameter int P_LB_ADDR_W = 12,
   parameter int P_LB_DATA_W = 16,
   parameter int P_TO_W      = 8,
   parameter int P_TIMEOUT   = 255
) (
   input  logic                   clk_ir,
   input  logic                   rst_il,
   input  logic                   m0_req_ih,
   input  logic                   m0_wr_ih,
   input  logic [P_LB_ADDR_W-1:0] m0_addr_id,
   input  logic [P_LB_DATA_W-1:0] m0_wr_data_id,
   output logic                   m0_done_oh,
   output logic                   m0_err_oh,
   output logic [P_LB_DATA_W-1:0] m0_rd_data_od,
   input  logic                   m1_req_ih,
   input  logic                   m1_wr_ih,
   input  logic [P_LB_ADDR_W-1:0] m1_addr_id,
   input  logic [P_LB_DATA_W-1:0] m1_wr_data_id,
   output logic                   m1_done_oh,
   output logic                   m1_err_oh,
   output logic [P_LB_DATA_W-1:0] m1_rd_data_od,
   output logic                   lb_rd_en_oh,
   output logic                   lb_wr_en_oh,
   output logic [P_LB_ADDR_W-1:0] lb_addr_od,
   output logic [P_LB_DATA_W-1:0] lb_wr_data_od,
   input  logic                   lb_rd_valid_ih,
   input  logic [P_LB_DATA_W-1:0] lb_rd_data_id,
   input  logic                   lb_wr_valid_ih,
   output logic [1:0]             arb_gnt_od,
   output logic                   arb_busy_oh
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [P_TO_W-1:0]      LP_TO_LAST = P_TO_W'(P_TIMEOUT - 1);
   localparam logic [P_LB_DATA_W-1:0] LP_DEAD    = P_LB_DATA_W'(16'hdead);

   logic [1:0]             r_state;
   logic                   r_last;
   logic                   r_own;
   logic                   r_wr;
   logic [P_TO_W-1:0]      r_cnt;
   logic                   r_m0_done;
   logic                   r_m0_err;
   logic [P_LB_DATA_W-1:0] r_m0_rd;
   logic                   r_m1_done;
   logic                   r_m1_err;
   logic [P_LB_DATA_W-1:0] r_m1_rd;
   logic                   r_rd_en;
   logic                   r_wr_en;
   logic [P_LB_ADDR_W-1:0] r_addr;
   logic [P_LB_DATA_W-1:0] r_wdata;
   logic [1:0]             r_gnt;
   logic                   r_busy;

   logic                   w_any;
   logic                   w_sel;
   logic                   w_wr;
   logic                   w_acc;
   logic                   w_to;

   assign w_any = m0_req_ih | m1_req_ih;
   assign w_wr  = w_sel ? m1_wr_ih : m0_wr_ih;
   assign w_acc = r_wr ? lb_wr_valid_ih : lb_rd_valid_ih;
   assign w_to  = (r_cnt == LP_TO_LAST);

   // On a tie the master that did not own the bus last time wins.
   always_comb begin
      w_sel = 1'b0;
      unique case (1'b1)
         (m0_req_ih & m1_req_ih):  w_sel = ~r_last;
         (~m0_req_ih & m1_req_ih): w_sel = 1'b1;
         default:                  w_sel = 1'b0;
      endcase
   end

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         r_state   <= S_IDLE;
         r_last    <= 1'b1;
         r_own     <= 1'b0;
         r_wr      <= 1'b0;
         r_cnt     <= '0;
         r_m0_done <= 1'b0;
         r_m0_err  <= 1'b0;
         r_m0_rd   <= '0;
         r_m1_done <= 1'b0;
         r_m1_err  <= 1'b0;
         r_m1_rd   <= '0;
         r_rd_en   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_gnt     <= 2'b00;
         r_busy    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_own   <= w_sel;
                  r_wr    <= w_wr;
                  r_addr  <= w_sel ? m1_addr_id : m0_addr_id;
                  r_wdata <= w_sel ? m1_wr_data_id : m0_wr_data_id;
                  r_wr_en <= w_wr;
                  r_rd_en <= ~w_wr;
                  r_gnt   <= w_sel ? 2'b10 : 2'b01;
                  r_busy  <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_wr_en <= 1'b0;
               r_rd_en <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // A valid in the last counted cycle still wins over timeout.
               if (w_acc || w_to) begin
                  r_m0_done <= ~r_own;
                  r_m1_done <= r_own;
                  r_m0_err  <= ~r_own & ~w_acc;
                  r_m1_err  <= r_own & ~w_acc;
                  if (!r_wr) begin
                     if (r_own) r_m1_rd <= w_acc ? lb_rd_data_id : LP_DEAD;
                     else       r_m0_rd <= w_acc ? lb_rd_data_id : LP_DEAD;
                  end
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_m0_done <= 1'b0;
               r_m1_done <= 1'b0;
               r_m0_err  <= 1'b0;
               r_m1_err  <= 1'b0;
               r_gnt     <= 2'b00;
               r_busy    <= 1'b0;
               r_last    <= r_own;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m0_done_oh    = r_m0_done;
   assign m0_err_oh     = r_m0_err;
   assign m0_rd_data_od = r_m0_rd;
   assign m1_done_oh    = r_m1_done;
   assign m1_err_oh     = r_m1_err;
   assign m1_rd_data_od = r_m1_rd;
   assign lb_rd_en_oh   = r_rd_en;
   assign lb_wr_en_oh   = r_wr_en;
   assign lb_addr_od    = r_addr;
   assign lb_wr_data_od = r_wdata;
   assign arb_gnt_od    = r_gnt;
   assign arb_busy_oh   = r_busy;

endmodule
